// File: rtl/tia_audio_mixer.sv
// ---------------------------------------------------------------------------
// tia_audio_mixer
//
// Purpose:
//   Sits behind the two TIA audio channel circuits. On every audio_tick it
//   forms the mixed level of both channels (each channel contributes its
//   AUDV volume when its poly bit is 1). The level then goes to two places.
//   It is pushed into a 2-entry PCM FIFO that has a valid/ready handshake.
//   It is also held in mix_q, which feeds a 1-bit DAC.
//
// Build option:
//   TIA_AUDIO_SIGMA_DELTA_EN - when defined, the DAC is a first-order
//   sigma-delta modulator instead of the default PWM generator. The FIFO
//   and handshake are the same in both builds.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   audio_tick  one-cycle enable at the audio sample rate
//   ch0_bit     channel 0 poly output bit
//   ch1_bit     channel 1 poly output bit
//   ch0_vol     channel 0 AUDV volume (VOL_WIDTH bits)
//   ch1_vol     channel 1 AUDV volume (VOL_WIDTH bits)
//   pcm_data    head of the PCM FIFO (VOL_WIDTH+1 bits)
//   pcm_valid   pcm_data holds a sample
//   pcm_ready   consumer takes the head sample this cycle
//   overflow    sticky flag, set when a sample was dropped; cleared by rst
//   dac_out     registered 1-bit DAC drive
// ---------------------------------------------------------------------------
module tia_audio_mixer #(
    parameter int PWM_PERIOD = 31,
    parameter int VOL_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 audio_tick,
    input  logic                 ch0_bit,
    input  logic                 ch1_bit,
    input  logic [VOL_WIDTH-1:0] ch0_vol,
    input  logic [VOL_WIDTH-1:0] ch1_vol,
    output logic [VOL_WIDTH:0]   pcm_data,
    output logic                 pcm_valid,
    input  logic                 pcm_ready,
    output logic                 overflow,
    output logic                 dac_out
);

    // The level is one bit wider than a volume, so two full-scale volumes
    // (15 + 15 = 30) fit without saturation.
    localparam int LVL_W = VOL_WIDTH + 1;

    // -----------------------------------------------------------------------
    // Mixer: each channel contributes its volume only while its poly bit
    // is high. The sum is formed at full level width.
    // -----------------------------------------------------------------------
    logic [LVL_W-1:0] term0;
    logic [LVL_W-1:0] term1;
    logic [LVL_W-1:0] level;

    always_comb begin
        term0 = '0;
        term1 = '0;
        if (ch0_bit) begin
            term0 = {1'b0, ch0_vol};
        end
        if (ch1_bit) begin
            term1 = {1'b0, ch1_vol};
        end
        level = term0 + term1;
    end

    // -----------------------------------------------------------------------
    // Mix register: holds the level of the most recent tick. This register
    // feeds the DAC, so it is updated on every tick, even when the FIFO has
    // to drop the sample.
    // -----------------------------------------------------------------------
    logic [LVL_W-1:0] mix_q;
    logic [LVL_W-1:0] mix_d;

    always_comb begin
        mix_d = mix_q;
        if (audio_tick) begin
            mix_d = level;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mix_q <= '0;
        end else begin
            mix_q <= mix_d;
        end
    end

    // -----------------------------------------------------------------------
    // PCM FIFO with two entries.
    //
    // head_q is the oldest sample and drives pcm_data directly. There is no
    // bypass, so a pushed sample shows up no earlier than the next cycle.
    // tail_q holds the second sample when count_q is 2.
    //
    // The FIFO pops only when it holds a sample. A ready signal on an empty
    // FIFO therefore has no effect.
    //
    // When the FIFO is full and a push arrives:
    //   - With no pop on the same edge, the new sample is dropped and the
    //     overflow flag is set.
    //   - With a pop on the same edge, the pop makes room, so the push is
    //     accepted and no overflow occurs.
    // -----------------------------------------------------------------------
    logic [LVL_W-1:0] head_q;
    logic [LVL_W-1:0] head_d;
    logic [LVL_W-1:0] tail_q;
    logic [LVL_W-1:0] tail_d;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             pop;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        pop     = (count_q != 2'd0) && pcm_ready;

        case ({pop, audio_tick})
            2'b01: begin
                case (count_q)
                    2'd0: begin
                        head_d  = level;
                        count_d = 2'd1;
                    end
                    2'd1: begin
                        tail_d  = level;
                        count_d = 2'd2;
                    end
                    default: begin
                        ovf_d = 1'b1;
                    end
                endcase
            end
            2'b10: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Pop and push on the same edge, so the occupancy stays
                // the same.
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = level;
                end else begin
                    head_d = level;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pcm_data  = head_q;
    assign pcm_valid = (count_q != 2'd0);
    assign overflow  = ovf_q;

`ifdef TIA_AUDIO_SIGMA_DELTA_EN
    // -----------------------------------------------------------------------
    // Sigma-delta DAC.
    //
    // Each cycle the accumulator adds mix_q. Whenever the sum reaches full
    // scale (31), the DAC emits a 1 and full scale is subtracted.
    //
    // The accumulator always stays below 31. As a result, a constant mix_q
    // returns the accumulator to the same value after 31 cycles, and any
    // 31-cycle window contains exactly mix_q ones.
    // -----------------------------------------------------------------------
    localparam logic [LVL_W:0] SD_FULL = (LVL_W + 1)'((1 << LVL_W) - 1);

    logic [LVL_W-1:0] acc_q;
    logic [LVL_W-1:0] acc_d;
    logic [LVL_W:0]   sum;
    logic             dac_q;
    logic             dac_d;

    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, mix_q};
        if (sum >= SD_FULL) begin
            dac_d = 1'b1;
            acc_d = LVL_W'(sum - SD_FULL);
        end else begin
            dac_d = 1'b0;
            acc_d = sum[LVL_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            dac_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            dac_q <= dac_d;
        end
    end

    assign dac_out = dac_q;
`else
    // -----------------------------------------------------------------------
    // PWM DAC.
    //
    // pwm_cnt runs from 0 to PWM_PERIOD-1. duty_q is reloaded from mix_q
    // only on the wrap edge, so a tick that arrives mid-frame cannot glitch
    // the frame in progress.
    //
    // dac_out is high while pwm_cnt < duty_q, which gives exactly duty_q
    // high cycles per frame.
    // -----------------------------------------------------------------------
    localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int CMP_W = (CNT_W > LVL_W) ? CNT_W : LVL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PWM_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [LVL_W-1:0] duty_q;
    logic [LVL_W-1:0] duty_d;
    logic             dac_q;
    logic             dac_d;
    logic             wrap;

    always_comb begin
        wrap   = (cnt_q == CNT_MAX);
        cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
        duty_d = wrap ? mix_q : duty_q;
        dac_d  = (CMP_W'(cnt_q) < CMP_W'(duty_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            duty_q <= '0;
            dac_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            dac_q  <= dac_d;
        end
    end

    assign dac_out = dac_q;
`endif

endmodule

// File: tb/tb_tia_audio_mixer.sv
// ---------------------------------------------------------------------------
// Self-checking testbench for tia_audio_mixer.
//
// The bench runs directed scenarios followed by a randomized run. In the
// randomized run, the PCM FIFO behaviour is predicted by a queue-based
// reference model kept in the bench.
// ---------------------------------------------------------------------------
module tb_tia_audio_mixer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       audio_tick = 1'b0;
    logic       ch0_bit = 1'b0;
    logic       ch1_bit = 1'b0;
    logic [3:0] ch0_vol = 4'd0;
    logic [3:0] ch1_vol = 4'd0;
    logic [4:0] pcm_data;
    logic       pcm_valid;
    logic       pcm_ready = 1'b0;
    logic       overflow;
    logic       dac_out;

    int total = 0;
    int bad   = 0;

    tia_audio_mixer #(.PWM_PERIOD(31), .VOL_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .audio_tick (audio_tick),
        .ch0_bit    (ch0_bit),
        .ch1_bit    (ch1_bit),
        .ch0_vol    (ch0_vol),
        .ch1_vol    (ch1_vol),
        .pcm_data   (pcm_data),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .overflow   (overflow),
        .dac_out    (dac_out)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Advance one clock edge and move 1 unit past it. Inputs are driven
    // here, and outputs are sampled here too, away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the channel inputs so that the mixed level equals l (0..30).
    task automatic set_level(input int l);
        int a;
        a = (l > 15) ? 15 : l;
        ch0_bit = (l != 0);
        ch1_bit = (l != 0);
        ch0_vol = 4'(a);
        ch1_vol = 4'(l - a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        audio_tick = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Count dac_out high cycles over 31 consecutive cycles, after a settle
    // time long enough for the DAC to track a new level.
    task automatic count_ones(output int ones);
        ones = 0;
        repeat (70) step();
        for (int i = 0; i < 31; i++) begin
            step();
            if (dac_out === 1'b1) ones++;
        end
    endtask

    // Hold rst for two cycles with random inputs applied, then release it
    // with no ticks and confirm the DAC stays silent.
    task automatic test_reset();
        int ones;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            audio_tick = 1'($urandom);
            ch0_bit    = 1'($urandom);
            ch1_bit    = 1'($urandom);
            ch0_vol    = 4'($urandom);
            ch1_vol    = 4'($urandom);
            pcm_ready  = 1'($urandom);
            step();
            total++;
            if ({pcm_valid, pcm_data, overflow, dac_out} !== 8'd0) begin
                bad++;
                $display("[TB] FAIL reset_outputs: got valid=%0b data=%0d ovf=%0b dac=%0b, want all 0",
                         pcm_valid, pcm_data, overflow, dac_out);
            end
        end
        rst = 1'b0;
        audio_tick = 1'b0;
        ones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dac_out !== 1'b0) ones++;
        end
        total++;
        if (ones != 0) begin
            bad++;
            $display("[TB] FAIL reset_dac_idle: got %0d non-zero cycles, want 0", ones);
        end
    endtask

    // One tick per pattern with the consumer ready. The sample must be
    // visible the cycle after the tick, then popped on the following edge.
    task automatic test_mix();
        bit       b0 [3] = '{1'b1, 1'b0, 1'b1};
        bit       b1 [3] = '{1'b1, 1'b1, 1'b1};
        int       v0 [3] = '{15, 15, 15};
        int       v1 [3] = '{7, 9, 15};
        int       exp_l [3] = '{22, 9, 30};
        pcm_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ch0_bit = b0[i];
            ch1_bit = b1[i];
            ch0_vol = 4'(v0[i]);
            ch1_vol = 4'(v1[i]);
            audio_tick = 1'b1;
            step();
            audio_tick = 1'b0;
            total++;
            if (pcm_valid !== 1'b1 || pcm_data !== 5'(exp_l[i])) begin
                bad++;
                $display("[TB] FAIL mix_%0d: got valid=%0b data=%0d, want valid=1 data=%0d",
                         i, pcm_valid, pcm_data, exp_l[i]);
            end
            step();
            total++;
            if (pcm_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL mix_pop_%0d: got valid=%0b, want 0", i, pcm_valid);
            end
        end
    endtask

    // Three ticks while the consumer is stalled. The third sample is
    // dropped and overflow is set; draining then returns only 3 and 5.
    task automatic test_backpressure();
        int lv [3] = '{3, 5, 7};
        do_reset();
        pcm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_level(lv[i]);
            audio_tick = 1'b1;
            step();
        end
        audio_tick = 1'b0;
        total++;
        if (overflow !== 1'b1 || pcm_valid !== 1'b1 || pcm_data !== 5'd3) begin
            bad++;
            $display("[TB] FAIL bp_full: got ovf=%0b valid=%0b data=%0d, want ovf=1 valid=1 data=3",
                     overflow, pcm_valid, pcm_data);
        end
        step();
        total++;
        if (pcm_data !== 5'd3) begin
            bad++;
            $display("[TB] FAIL bp_stable: got data=%0d, want 3", pcm_data);
        end
        pcm_ready = 1'b1;
        step();
        total++;
        if (pcm_valid !== 1'b1 || pcm_data !== 5'd5) begin
            bad++;
            $display("[TB] FAIL bp_drain: got valid=%0b data=%0d, want valid=1 data=5",
                     pcm_valid, pcm_data);
        end
        step();
        total++;
        if (pcm_valid !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_empty: got valid=%0b ovf=%0b, want valid=0 ovf=1",
                     pcm_valid, overflow);
        end
    endtask

    // Full FIFO with a push and a pop on the same edge: the push must be
    // accepted without overflow, and the output sequence is 1, 2, 4.
    task automatic test_push_pop();
        int got [$];
        do_reset();
        pcm_ready = 1'b0;
        set_level(1);
        audio_tick = 1'b1;
        step();
        set_level(2);
        step();
        set_level(4);
        pcm_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (pcm_valid === 1'b1) got.push_back(int'(pcm_data));
            step();
            audio_tick = 1'b0;
        end
        total++;
        if (got.size() != 3 || got[0] != 1 || got[1] != 2 || got[2] != 4) begin
            bad++;
            $display("[TB] FAIL pushpop_seq: got %p, want '{1, 2, 4}", got);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL pushpop_ovf: got ovf=%0b, want 0", overflow);
        end
    endtask

    // For a held level, the DAC ones density over 31 cycles equals the
    // level. This holds for both the PWM and the sigma-delta build.
    task automatic test_dac();
        int lv [4] = '{10, 0, 30, 17};
        int ones;
        do_reset();
        pcm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_level(lv[i]);
            audio_tick = 1'b1;
            step();
            audio_tick = 1'b0;
            count_ones(ones);
            total++;
            if (ones != lv[i]) begin
                bad++;
                $display("[TB] FAIL dac_level_%0d: got %0d high of 31, want %0d", lv[i], ones, lv[i]);
            end
        end
    endtask

    // Reset mid-operation: with the FIFO full, overflow set and dac_out
    // high, one cycle of rst clears everything. The next tick then behaves
    // like the first tick after power-up.
    task automatic test_reset_mid();
        int wait_cnt;
        do_reset();
        pcm_ready = 1'b0;
        set_level(9);
        audio_tick = 1'b1;
        step();
        step();
        set_level(30);
        step();
        audio_tick = 1'b0;
        wait_cnt = 0;
        while (dac_out !== 1'b1 && wait_cnt < 100) begin
            step();
            wait_cnt++;
        end
        total++;
        if (dac_out !== 1'b1 || overflow !== 1'b1 || pcm_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_setup: got dac=%0b ovf=%0b valid=%0b, want 1 1 1",
                     dac_out, overflow, pcm_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({pcm_valid, pcm_data, overflow, dac_out} !== 8'd0) begin
            bad++;
            $display("[TB] FAIL midrst_clear: got valid=%0b data=%0d ovf=%0b dac=%0b, want all 0",
                     pcm_valid, pcm_data, overflow, dac_out);
        end
        set_level(12);
        audio_tick = 1'b1;
        step();
        audio_tick = 1'b0;
        total++;
        if (pcm_valid !== 1'b1 || pcm_data !== 5'd12) begin
            bad++;
            $display("[TB] FAIL midrst_tick: got valid=%0b data=%0d, want valid=1 data=12",
                     pcm_valid, pcm_data);
        end
    endtask

    // Randomized ticks, channels and ready. The reference model is a
    // bounded queue with a sticky drop flag.
    task automatic test_random();
        int  q [$];
        bit  m_ovf;
        bit  pop;
        int  lvl;
        do_reset();
        m_ovf = 1'b0;
        for (int i = 0; i < 400; i++) begin
            audio_tick = ($urandom_range(0, 1) == 1);
            pcm_ready  = ($urandom_range(0, 2) != 0);
            ch0_bit    = 1'($urandom);
            ch1_bit    = 1'($urandom);
            ch0_vol    = 4'($urandom);
            ch1_vol    = 4'($urandom);
            lvl = (ch0_bit ? int'(ch0_vol) : 0) + (ch1_bit ? int'(ch1_vol) : 0);
            pop = (q.size() > 0) && pcm_ready;
            if (pop) void'(q.pop_front());
            if (audio_tick) begin
                if (q.size() < 2) q.push_back(lvl);
                else m_ovf = 1'b1;
            end
            step();
            total++;
            if (pcm_valid !== (q.size() > 0) || overflow !== m_ovf) begin
                bad++;
                $display("[TB] FAIL rand_flags@%0d: got valid=%0b ovf=%0b, want valid=%0b ovf=%0b",
                         i, pcm_valid, overflow, (q.size() > 0), m_ovf);
            end
            if (q.size() > 0) begin
                total++;
                if (pcm_data !== 5'(q[0])) begin
                    bad++;
                    $display("[TB] FAIL rand_data@%0d: got %0d, want %0d", i, pcm_data, q[0]);
                end
            end
        end
        audio_tick = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_mix();
        test_backpressure();
        test_push_pop();
        test_dac();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tia_audio_mixer.md
Name: tia_audio_mixer

Overview:
- Downstream of the per-channel TIA audio circuit (polynomial shift-register stage).
- Takes each channel's current poly output bit and its 4-bit AUDV volume, and forms the mixed 5-bit level once per audio clock tick.
- Pushes each level into a 2-entry PCM output buffer with a valid/ready handshake.
- Drives a 1-bit DAC pin (PWM by default) from the most recent level.

Parameters:
- PWM_PERIOD, 31, DAC frame length in clk cycles; counter runs 0..PWM_PERIOD-1. Must be ≥ 31 so the max level 30 never saturates.
- VOL_WIDTH, 4, per-channel volume width; fixed at 4 for TIA compatibility.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- audio_tick  in  1  one-cycle enable at the audio sample rate (~31.4 kHz equivalent)
- ch0_bit  in  1  channel 0 poly output bit (shiftReg LSB of channel 0 audio circuit)
- ch1_bit  in  1  channel 1 poly output bit
- ch0_vol  in  4  channel 0 AUDV volume
- ch1_vol  in  4  channel 1 AUDV volume
- pcm_data  out  5  head of PCM buffer
- pcm_valid  out  1  pcm_data holds a sample
- pcm_ready  in  1  consumer accepts the sample this cycle
- overflow  out  1  sticky: a sample was dropped
- dac_out  out  1  1-bit DAC drive

Behaviour:
- Reset: all outputs read 0 the cycle after any clk edge with rst=1.
  - pcm_data=0, pcm_valid=0, overflow=0, dac_out=0.
  - Buffer is emptied, pwm_cnt=0, duty_reg=0, mix_reg=0.
  - rst dominates all other inputs, including mid-frame and with a full buffer.
- Mix: level = (ch0_bit ? ch0_vol : 0) + (ch1_bit ? ch1_vol : 0), computed zero-extended to 5 bits; range 0..30, no saturation.
- Sampling:
  - Inputs are sampled only on edges where audio_tick=1.
  - On that edge, mix_reg <= level and the level is pushed into the buffer.
  - Latency 1: when the buffer was empty, pcm_valid=1 and pcm_data=level in the cycle after the tick.
- Buffer: 2-entry FIFO, in order.
  - Pop occurs on an edge where pcm_valid & pcm_ready.
  - pcm_data must be stable while pcm_valid=1 and pcm_ready=0.
  - Full, push, no pop: new sample dropped, stored samples unchanged, overflow <= 1 (cleared only by rst).
  - Full, push, pop on the same edge: pop the head, accept the push, no overflow.
  - Empty with pcm_ready=1: no pop, no underflow; pcm_valid stays 0.
  - No pcm_data bypass: a pushed sample is visible no earlier than the next cycle.
- PWM DAC (default):
  - pwm_cnt increments every clk and wraps PWM_PERIOD-1 -> 0.
  - duty_reg <= mix_reg only on the wrap edge, so the duty is glitch-free within a frame.
  - dac_out is registered: dac_out <= (pwm_cnt < duty_reg).
  - duty 0 gives constant 0. Duty 30 with period 31 gives 30 high and 1 low per frame.
  - audio_tick arriving mid-frame affects the next frame only.
- audio_tick asserted on consecutive cycles is legal; every cycle counts as a separate tick.

Optional Feature:
- Macro: TIA_AUDIO_SIGMA_DELTA_EN.
- When defined:
  - The PWM counter and duty_reg are removed. A 5-bit accumulator acc (reset 0) is used instead.
  - Each clk: sum = acc + mix_reg (6-bit). If sum ≥ 31, then dac_out <= 1 and acc <= sum-31; otherwise dac_out <= 0 and acc <= sum.
  - The mix_reg change takes effect on the next clk.
  - Ones density over any 31 consecutive cycles with constant mix_reg equals mix_reg exactly.
- When undefined: PWM behaviour as above.
- The buffer and handshake are identical in both builds.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> pcm_valid=0, pcm_data=0, overflow=0, dac_out=0. Release -> dac_out stays 0 with no ticks.
- Mix: ch0_bit=1 vol 15, ch1_bit=1 vol 7, pcm_ready=1, one tick -> next cycle pcm_valid=1, pcm_data=22. Repeat with ch0_bit=0 vol 15, ch1_bit=1 vol 9 -> pcm_data=9. Repeat with both bits 1 and vols 15/15 -> 30.
- Backpressure: pcm_ready=0, three ticks with levels 3, 5, 7 -> overflow=1 after the third, and pcm_data holds 3. Raise pcm_ready -> 3 then 5 drain, pcm_valid drops, 7 never appears.
- Simultaneous push/pop: buffer full (levels 1, 2), pcm_ready=1 on a tick with level 4 -> overflow stays 0, and the output sequence is 1, 2, 4.
- DAC: mix_reg=10 held -> dac_out high exactly 10 of 31 cycles per frame. The sigma-delta build gives 10 ones per 31 cycles. Level 0 gives all low; level 30 gives 30 high.
- Reset mid-operation: buffer full, overflow=1, dac_out=1 mid-frame; assert rst 1 cycle -> next cycle all outputs 0. The next tick produces pcm_valid with the new level.
